fb_swapchain: RTL

Parametrised multi-buffer framebuffer. It generalises the two-bank ping-pong design to NBUF = 2 (double) or 3 (triple) buffering on a single clock. Buffer swaps are synchronised to the LCD scan-out frame boundary, and it has a registered, fixed-latency read port. It sits between the pixel renderer (write side) and the raw LCD timing engine (read side).

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_bank.sv | 38 +++
 rtl/fb_swapchain.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the fb_swapchain framebuffer:
//   IDX_W          width of a buffer index (front/back/ready slot)
//   swap_state_t   double-buffer swap FSM states
//   nbuf_is_legal  elaboration-time check of the buffer count
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,   // back buffer open for writes
        PEND = 1'b1    // frame finished, waiting for the scan-out frame boundary
    } swap_state_t;

    function automatic bit nbuf_is_legal(input int n);
        return (n == 2) || (n == 3);
    endfunction

endpackage

// File: rtl/fb_bank.sv
// -----------------------------------------------------------------------------
// fb_bank
// One frame buffer: single-clock simple dual-port RAM, DATA_W x DEPTH,
// synchronous write and synchronous (registered) read.
// Ports:
//   clk            clock
//   we/waddr/wdata write port (caller guarantees waddr < DEPTH when we=1)
//   re/raddr       read strobe/address (caller guarantees raddr < DEPTH when re=1)
//   rdata          read data, valid the cycle after re; holds while re=0
// -----------------------------------------------------------------------------
module fb_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset so the tools can map
    // them onto block RAM; frame contents survive a reset by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fb_swapchain.sv
// -----------------------------------------------------------------------------
// fb_swapchain
// Double (NBUF=2) or triple (NBUF=3) buffered framebuffer between a pixel
// renderer and an LCD scan-out engine. Buffer swaps happen only on the frame
// boundary signalled by frame_end. Read latency is one cycle.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data     renderer writes into the back buffer
//   wr_ready                  back buffer accepts writes
//   swap_req                  renderer finished the back frame (pulse)
//   swap_done                 front buffer changed (pulse)
//   rd_en/rd_addr             scan-out read into the front buffer
//   rd_data/rd_valid          read result, one cycle after rd_en
//   frame_end                 scan-out fetched the last pixel (pulse)
//   front_idx                 buffer currently displayed
//   drop_cnt                  saturating count of overwritten ready frames
// -----------------------------------------------------------------------------
module fb_swapchain
    import fb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17,
    parameter int NBUF   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              swap_req,
    output logic              swap_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              frame_end,
    output logic [IDX_W-1:0]  front_idx,
    output logic [15:0]       drop_cnt
);

    if (!nbuf_is_legal(NBUF)) begin : g_bad_nbuf
        $error("fb_swapchain: NBUF must be 2 or 3");
    end
    if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
        $error("fb_swapchain: ADDR_W too narrow for DEPTH");
    end

    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    // ---------------------------------------------------------------- swap state
    swap_state_t      state_q, state_d;
    logic [IDX_W-1:0] front_q, front_d;
    logic [IDX_W-1:0] back_q,  back_d;
    logic [IDX_W-1:0] ready_q, ready_d;   // fixed at 2 (unused) when NBUF=2
    logic             rv_q,    rv_d;      // ready slot holds a finished frame
    logic             swap_d;
    logic             drop_inc;
    logic             swap_done_q;
    logic [15:0]      drop_cnt_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            front_q     <= IDX_W'(0);
            back_q      <= IDX_W'(1);
            ready_q     <= IDX_W'(2);
            rv_q        <= 1'b0;
            swap_done_q <= 1'b0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            back_q      <= back_d;
            ready_q     <= ready_d;
            rv_q        <= rv_d;
            swap_done_q <= swap_d;
            if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        front_d  = front_q;
        back_d   = back_q;
        ready_d  = ready_q;
        rv_d     = rv_q;
        swap_d   = 1'b0;
        drop_inc = 1'b0;
        if (NBUF == 2) begin
            case (state_q)
                IDLE: begin
                    if (swap_req && frame_end) begin
                        front_d = back_q;
                        back_d  = front_q;
                        swap_d  = 1'b1;
                    end else if (swap_req) begin
                        state_d = PEND;
                    end
                end
                PEND: begin
                    // Further swap_req pulses are ignored until the boundary.
                    if (frame_end) begin
                        front_d = back_q;
                        back_d  = front_q;
                        swap_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            if (swap_req && frame_end) begin
                // Newest frame goes straight to the display; an older ready
                // frame (if any) is discarded and its slot stays the ready slot.
                front_d  = back_q;
                back_d   = front_q;
                rv_d     = 1'b0;
                swap_d   = 1'b1;
                drop_inc = rv_q;
            end else if (swap_req) begin
                ready_d  = back_q;
                back_d   = ready_q;
                rv_d     = 1'b1;
                drop_inc = rv_q;
            end else if (frame_end && rv_q) begin
                front_d = ready_q;
                ready_d = front_q;
                rv_d    = 1'b0;
                swap_d  = 1'b1;
            end
        end
    end

    always_comb begin
        // Only the double-buffer FSM ever leaves IDLE.
        wr_ready = (state_q == IDLE);
    end

    assign swap_done = swap_done_q;
    assign drop_cnt  = drop_cnt_q;
    assign front_idx = front_q;

    // ---------------------------------------------------------------- banks
    logic wr_in_range;
    logic rd_in_range;
    logic [DATA_W-1:0] bank_rdata [NBUF];

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

    for (genvar i = 0; i < NBUF; i++) begin : g_bank
        fb_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .we    (wr_en && wr_ready && wr_in_range && (back_q == IDX_W'(i))),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (rd_en && rd_in_range),
            .raddr (rd_addr),
            .rdata (bank_rdata[i])
        );
    end

    // ---------------------------------------------------------------- read port
    // rd_sel_q remembers which buffer was front when the read was issued, so a
    // read in the swap cycle still returns old-front data. rd_zero_q forces 0
    // after reset and for out-of-range reads; both hold while rd_en=0, which
    // together with the bank read register makes rd_data hold.
    logic [IDX_W-1:0] rd_sel_q;
    logic             rd_zero_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel_q   <= IDX_W'(0);
            rd_zero_q  <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_sel_q  <= front_q;
                rd_zero_q <= !rd_in_range;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (!rd_zero_q) begin
            for (int i = 0; i < NBUF; i++) begin
                if (rd_sel_q == IDX_W'(i)) begin
                    rd_data = bank_rdata[i];
                end
            end
        end
    end

    assign rd_valid = rd_valid_q;

endmodule
